mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_if.sv | 25 ++
 rtl/mem_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_lsu.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Request/response bus between a requester and the mem_lsu load/store unit.
interface mem_lsu_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_func;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_func, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_func, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a DATA_W-wide word array.
// Sub-word accesses use RISC-V funct3 size/sign encoding, right-aligned data.
//
// state | meaning
// IDLE  | ready, waiting for req_valid
// WAIT  | request captured, latency down-counter running
// RESP  | response presented, held until resp_ready
module mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic      clk,
  input logic      rstn,
  mem_lsu_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic              cap_wen;
  logic [2:0]        cap_func;
  logic [31:0]       cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              cnt_tc;
  logic              commit;
  logic [AW-1:0]     word_idx;
  logic [OFF-1:0]    byte_off;
  logic              illegal;
  logic              misaligned;
  logic              op_err;
  logic [NB-1:0]     lane_en;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] ld_val;
  logic              unused_addr_hi;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign cnt_tc   = (cnt == '0);
  // The array operation happens on the edge that moves WAIT -> RESP.
  // LATENCY=1 still passes one cycle through WAIT (counter already at
  // terminal count) so resp_valid appears LATENCY edges after acceptance.
  assign commit   = (state == WAIT) && cnt_tc;
  assign word_idx = cap_addr[OFF+AW-1:OFF];
  assign byte_off = cap_addr[OFF-1:0];
  assign unused_addr_hi = ^cap_addr[31:OFF+AW];
  assign wdata_sh = cap_wdata << {byte_off, 3'b000};
  assign rd_sh    = mem[word_idx] >> {byte_off, 3'b000};
  assign op_err   = illegal || misaligned;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; new requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = WAIT;
      WAIT:    if (cnt_tc) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; response payload is registered.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  // Capture the request on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_wen   <= bus.req_wen;
      cap_func  <= bus.req_func;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
    end
  end

  // Latency down-counter: loaded with LATENCY-1, stops at terminal count.
  always_ff @(posedge clk) begin
    if (!rstn)                      cnt <= '0;
    else if (accept)                cnt <= CW'(LATENCY - 1);
    else if (state == WAIT && !cnt_tc) cnt <= cnt - CW'(1);
  end

  // Illegal func decode; 64-bit forms do not exist on a 32-bit array.
  always_comb begin
    illegal = 1'b0;
    if (cap_wen)
      illegal = cap_func[2] || ((DATA_W == 32) && (cap_func[1:0] == 2'd3));
    else
      illegal = (cap_func == 3'b111) ||
                ((DATA_W == 32) && ((cap_func[1:0] == 2'd3) || (cap_func == 3'b110)));
  end

  // Alignment check against the access size.
  always_comb begin
    case (cap_func[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = cap_addr[0];
      2'd2:    misaligned = |cap_addr[1:0];
      default: misaligned = |cap_addr[2:0];
    endcase
  end

  // Byte lanes touched by a store: size bytes starting at byte_off.
  always_comb begin
    lane_en = '0;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(byte_off) && b < int'(byte_off) + (1 << cap_func[1:0]))
        lane_en[b] = 1'b1;
    end
  end

  // Load result: shifted word truncated to size, sign- or zero-extended.
  always_comb begin
    case (cap_func)
      3'b000:  ld_val = DATA_W'($signed(rd_sh[7:0]));
      3'b001:  ld_val = DATA_W'($signed(rd_sh[15:0]));
      3'b010:  ld_val = DATA_W'($signed(rd_sh[31:0]));
      3'b100:  ld_val = DATA_W'(rd_sh[7:0]);
      3'b101:  ld_val = DATA_W'(rd_sh[15:0]);
      3'b110:  ld_val = DATA_W'(rd_sh[31:0]);
      default: ld_val = rd_sh;
    endcase
  end

  // Register the response when entering RESP; stores and errors return 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= op_err;
      rdata_q <= (cap_wen || op_err) ? '0 : ld_val;
    end
  end

  // Array write: legal stores only, never while reset is asserted, never cleared.
  always_ff @(posedge clk) begin
    if (rstn && commit && cap_wen && !op_err) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: three instances (32b/LAT2, 64b/LAT3/DEPTH16,
// 32b/LAT1/DEPTH16). Stimulus pushes expected responses; a negedge monitor
// pops and compares on every response handshake.
module tb_mem_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  mem_lsu_if #(.DATA_W(32)) if_a ();
  mem_lsu_if #(.DATA_W(64)) if_b ();
  mem_lsu_if #(.DATA_W(32)) if_c ();

  mem_lsu #(.DATA_W(32), .DEPTH(1024), .LATENCY(2)) u_a (.clk(clk), .rstn(rstn), .bus(if_a.slave));
  mem_lsu #(.DATA_W(64), .DEPTH(16),   .LATENCY(3)) u_b (.clk(clk), .rstn(rstn), .bus(if_b.slave));
  mem_lsu #(.DATA_W(32), .DEPTH(16),   .LATENCY(1)) u_c (.clk(clk), .rstn(rstn), .bus(if_c.slave));

  logic        t_valid  [3];
  logic        t_wen    [3];
  logic [2:0]  t_func   [3];
  logic [31:0] t_addr   [3];
  logic [63:0] t_wdata  [3];
  logic        t_rready [3];
  logic        o_ready  [3];
  logic        o_valid  [3];
  logic        o_err    [3];
  logic [63:0] o_rdata  [3];

  assign if_a.req_valid  = t_valid[0];
  assign if_a.req_wen    = t_wen[0];
  assign if_a.req_func   = t_func[0];
  assign if_a.req_addr   = t_addr[0];
  assign if_a.req_wdata  = t_wdata[0][31:0];
  assign if_a.resp_ready = t_rready[0];
  assign o_ready[0] = if_a.req_ready;
  assign o_valid[0] = if_a.resp_valid;
  assign o_err[0]   = if_a.resp_err;
  assign o_rdata[0] = {32'h0, if_a.resp_rdata};

  assign if_b.req_valid  = t_valid[1];
  assign if_b.req_wen    = t_wen[1];
  assign if_b.req_func   = t_func[1];
  assign if_b.req_addr   = t_addr[1];
  assign if_b.req_wdata  = t_wdata[1];
  assign if_b.resp_ready = t_rready[1];
  assign o_ready[1] = if_b.req_ready;
  assign o_valid[1] = if_b.resp_valid;
  assign o_err[1]   = if_b.resp_err;
  assign o_rdata[1] = if_b.resp_rdata;

  assign if_c.req_valid  = t_valid[2];
  assign if_c.req_wen    = t_wen[2];
  assign if_c.req_func   = t_func[2];
  assign if_c.req_addr   = t_addr[2];
  assign if_c.req_wdata  = t_wdata[2][31:0];
  assign if_c.resp_ready = t_rready[2];
  assign o_ready[2] = if_c.req_ready;
  assign o_valid[2] = if_c.resp_valid;
  assign o_err[2]   = if_c.resp_err;
  assign o_rdata[2] = {32'h0, if_c.resp_rdata};

  typedef struct {
    string       nm;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {63'b0, act}, {63'b0, exp});
  endtask

  // Monitor: every response handshake is compared against the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rstn === 1'b1 && o_valid[d] === 1'b1 && t_rready[d] === 1'b1) begin
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp dut%0d: got rdata %h, expected no response", d, o_rdata[d]);
        end else begin
          case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          check({e.nm, "_rdata"}, o_rdata[d], e.rdata);
          check1({e.nm, "_err"}, o_err[d], e.err);
        end
      end
    end
  end

  // One complete transaction, with acceptance/latency/hold checks along the way.
  task automatic issue(input int d, input logic wen, input logic [2:0] func,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] er, input logic ee, input int hold,
                       input string nm);
    int   k;
    exp_t e;
    k = 0;
    while (o_ready[d] !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check1({nm, "_ready"}, o_ready[d], 1'b1);
    e.nm = nm; e.rdata = er; e.err = ee;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    t_wen[d] = wen; t_func[d] = func; t_addr[d] = addr; t_wdata[d] = wdata;
    t_valid[d] = 1'b1;
    @(posedge clk); #1;
    t_valid[d] = 1'b0;
    check1({nm, "_busy"}, o_ready[d], 1'b0);
    k = 0;
    while (o_valid[d] !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check({nm, "_lat"}, 64'(k), 64'(lat_of(d)));
    for (int i = 0; i < hold; i++) begin
      check1({nm, "_hold_valid"}, o_valid[d], 1'b1);
      check1({nm, "_hold_ready"}, o_ready[d], 1'b0);
      check({nm, "_hold_rdata"}, o_rdata[d], er);
      check1({nm, "_hold_err"}, o_err[d], ee);
      @(posedge clk); #1;
    end
    t_rready[d] = 1'b1;
    k = 0;
    while (o_valid[d] === 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check1({nm, "_done"}, o_valid[d], 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      t_valid[d] = 1'b0; t_wen[d] = 1'b0; t_func[d] = 3'b0;
      t_addr[d] = 32'h0; t_wdata[d] = 64'h0; t_rready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check1($sformatf("rst_valid%0d", d), o_valid[d], 1'b0);
      check1($sformatf("rst_ready%0d", d), o_ready[d], 1'b1);
      check($sformatf("rst_rdata%0d", d), o_rdata[d], 64'h0);
      check1($sformatf("rst_err%0d", d), o_err[d], 1'b0);
    end

    // 32-bit, LATENCY=2
    issue(0, 1'b1, 3'b010, 32'h10,   64'hDEADBEEF, 64'h0,        1'b0, 0, "sw_10");
    issue(0, 1'b0, 3'b000, 32'h13,   64'h0, 64'hFFFFFFDE,        1'b0, 0, "lb_13");
    issue(0, 1'b0, 3'b100, 32'h13,   64'h0, 64'h000000DE,        1'b0, 0, "lbu_13");
    issue(0, 1'b0, 3'b101, 32'h12,   64'h0, 64'h0000DEAD,        1'b0, 0, "lhu_12");
    issue(0, 1'b1, 3'b000, 32'h11,   64'h55, 64'h0,              1'b0, 0, "sb_11");
    issue(0, 1'b0, 3'b010, 32'h10,   64'h0, 64'hDEAD55EF,        1'b0, 0, "lw_10");
    issue(0, 1'b0, 3'b010, 32'h12,   64'h0, 64'h0,               1'b1, 0, "lw_mis");
    issue(0, 1'b1, 3'b001, 32'h11,   64'hFFFF, 64'h0,            1'b1, 0, "sh_mis");
    issue(0, 1'b0, 3'b011, 32'h10,   64'h0, 64'h0,               1'b1, 0, "ld_w32");
    issue(0, 1'b0, 3'b110, 32'h10,   64'h0, 64'h0,               1'b1, 0, "lwu_w32");
    issue(0, 1'b1, 3'b011, 32'h10,   64'hFFFFFFFF, 64'h0,        1'b1, 0, "sd_w32");
    issue(0, 1'b1, 3'b100, 32'h10,   64'h77, 64'h0,              1'b1, 0, "st_f4");
    issue(0, 1'b0, 3'b111, 32'h10,   64'h0, 64'h0,               1'b1, 0, "ld_f7");
    issue(0, 1'b0, 3'b010, 32'h10,   64'h0, 64'hDEAD55EF,        1'b0, 0, "lw_unchg");
    issue(0, 1'b0, 3'b001, 32'h10,   64'h0, 64'h000055EF,        1'b0, 0, "lh_10");
    issue(0, 1'b0, 3'b001, 32'h12,   64'h0, 64'hFFFFDEAD,        1'b0, 0, "lh_12");
    issue(0, 1'b1, 3'b010, 32'h1010, 64'h01020304, 64'h0,        1'b0, 0, "sw_wrap");
    t_rready[0] = 1'b0;
    issue(0, 1'b0, 3'b010, 32'h10,   64'h0, 64'h01020304,        1'b0, 5, "lw_bp");

    // Reset while a store sits in WAIT: store must not land.
    issue(0, 1'b1, 3'b010, 32'h20,   64'h11223344, 64'h0,        1'b0, 0, "sw_20");
    t_wen[0] = 1'b1; t_func[0] = 3'b010; t_addr[0] = 32'h20; t_wdata[0] = 64'hAAAAAAAA;
    t_valid[0] = 1'b1;
    @(posedge clk); #1;
    t_valid[0] = 1'b0;
    check1("abort_accepted", o_ready[0], 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check1("abort_valid", o_valid[0], 1'b0);
    check1("abort_ready", o_ready[0], 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check1("abort_no_resp", o_valid[0], 1'b0);
    issue(0, 1'b0, 3'b010, 32'h20,   64'h0, 64'h11223344,        1'b0, 0, "lw_20_rst");

    // 64-bit, DEPTH=16, LATENCY=3
    issue(1, 1'b1, 3'b011, 32'h80, 64'h0123456789ABCDEF, 64'h0,  1'b0, 0, "sd_80");
    issue(1, 1'b0, 3'b011, 32'h0,  64'h0, 64'h0123456789ABCDEF,  1'b0, 0, "ld_0");
    issue(1, 1'b0, 3'b110, 32'h4,  64'h0, 64'h0000000001234567,  1'b0, 0, "lwu_4");
    issue(1, 1'b0, 3'b010, 32'h0,  64'h0, 64'hFFFFFFFF89ABCDEF,  1'b0, 0, "lw_0");
    issue(1, 1'b0, 3'b000, 32'h7,  64'h0, 64'h0000000000000001,  1'b0, 0, "lb_7");
    issue(1, 1'b0, 3'b100, 32'h3,  64'h0, 64'h0000000000000089,  1'b0, 0, "lbu_3");
    issue(1, 1'b0, 3'b000, 32'h3,  64'h0, 64'hFFFFFFFFFFFFFF89,  1'b0, 0, "lb_3");
    issue(1, 1'b0, 3'b011, 32'h4,  64'h0, 64'h0,                 1'b1, 0, "ld_mis");
    issue(1, 1'b1, 3'b011, 32'h8,  64'h1111111111111111, 64'h0,  1'b0, 0, "sd_8");
    issue(1, 1'b1, 3'b010, 32'hC,  64'hCAFEBABE, 64'h0,          1'b0, 0, "sw_c");
    issue(1, 1'b0, 3'b011, 32'h8,  64'h0, 64'hCAFEBABE11111111,  1'b0, 0, "ld_8");
    issue(1, 1'b0, 3'b001, 32'hE,  64'h0, 64'hFFFFFFFFFFFFCAFE,  1'b0, 0, "lh_e");
    issue(1, 1'b1, 3'b100, 32'h8,  64'h5, 64'h0,                 1'b1, 0, "st_f4_64");

    // 32-bit, DEPTH=16, LATENCY=1
    issue(2, 1'b1, 3'b010, 32'h4,  64'h80000001, 64'h0,          1'b0, 0, "sw_4");
    issue(2, 1'b0, 3'b010, 32'h44, 64'h0, 64'h80000001,          1'b0, 0, "lw_44");
    issue(2, 1'b0, 3'b001, 32'h6,  64'h0, 64'hFFFF8000,          1'b0, 0, "lh_6");
    issue(2, 1'b0, 3'b101, 32'h6,  64'h0, 64'h00008000,          1'b0, 0, "lhu_6");
    issue(2, 1'b1, 3'b001, 32'h4,  64'h1234, 64'h0,              1'b0, 0, "sh_4");
    issue(2, 1'b0, 3'b010, 32'h4,  64'h0, 64'h80001234,          1'b0, 0, "lw_4");

    @(negedge clk);
    check("q_a_left", 64'(q0.size()), 64'd0);
    check("q_b_left", 64'(q1.size()), 64'd0);
    check("q_c_left", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
